psum_deskew_acc: RTL
====================

# psum_deskew_acc

Output stage of the 8x8 weight-stationary systolic array. Captures the skewed right-edge partial sums (one 19-bit word per row, row r arriving r cycles after row 0) and realigns them into one vector. It accumulates vectors across K-tiles in an internal accumulator bank and pushes finished result vectors into a small output FIFO with a valid/ready handshake.

## Interface
- ROWS, 8, array rows = number of lanes
- PSUM_BW, 19, width of each incoming partial sum (signed)
- ACC_BW, 24, accumulator and output lane width (signed)
- VEC_CNT, 8, vectors per tile = accumulator bank depth
- FIFO_DEPTH, 4, output FIFO entries
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- psum_in  in  ROWS*PSUM_BW  lane r at bits [r*PSUM_BW +: PSUM_BW], fed by array row r's PSUM_OUT
- psum_valid  in  1  qualifies lane 0 in the current cycle; lane r is implicitly valid r cycles later
- tile_first  in  1  sampled with psum_valid; this vector overwrites its accumulator slot
- tile_last  in  1  sampled with psum_valid; this vector's result is pushed to the FIFO
- out_data  out  ROWS*ACC_BW  FIFO head, lane r at bits [r*ACC_BW +: ACC_BW]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- ovf  out  1  sticky: result dropped because FIFO was full
- busy  out  1  any valid in the deskew pipe or FIFO non-empty

## Operation
- Deskew: lane r passes through ROWS-1-r registers; lane ROWS-1 is used directly. psum_valid, tile_first and tile_last go through a ROWS-1 stage shift register, so the aligned vector and its control bits coincide.
- Accumulate on aligned valid, slot ptr: sum[r] = (first ? 0 : acc[ptr][r]) + sext(lane r). acc[ptr] <= sum. Two's-complement wrap at ACC_BW, no saturation.
- ptr: 0..VEC_CNT-1. Increments on each aligned valid and wraps VEC_CNT-1 -> 0. It is not reset by tile_first, so tiles must be VEC_CNT vectors long.
- If the aligned last bit is set, sum (not the old acc) is pushed into the FIFO in the same cycle.
- tile_first && tile_last: single-tile pass; result = sext(psum).
- FIFO: registered, no fall-through.
  - Pop on out_valid && out_ready.
  - A push when full with no simultaneous pop drops the vector and sets ovf.
  - A push and pop in the same cycle while full is legal and loses nothing.
  - A push into an empty FIFO appears on out_data the next cycle.
- ovf is cleared only by rst.
- Reset, including mid-operation, clears:
  - all deskew valid/control bits
  - ptr to 0
  - the FIFO (pointers, count)
  - out_valid, ovf and busy to 0; out_data to 0
- Accumulator contents need not be cleared, because tile_first defines them.
- In-flight vectors at reset are discarded.

## Timing
- Row-0 data is present in cycle 0 with psum_valid=1. Lane r must be present in cycle r.
- The aligned vector forms combinationally in cycle ROWS-1 (7). The acc write and FIFO push occur at the end of cycle ROWS-1.
- out_valid rises in cycle ROWS (8) if the FIFO was empty.
- Throughput is one vector per cycle. Back-to-back psum_valid needs no bubbles.
- The array cannot be stalled. The upstream controller must keep ≤ FIFO_DEPTH undrained result vectors, or ovf fires.
- busy is 0 in the cycle after the last FIFO pop with an empty pipe.

## Test plan
- Single pass: lane r = r+1 in cycle r, tile_first=tile_last=1, out_ready=1 -> cycle 8 out_valid=1 with lanes {1..8}; cycle 9 out_valid=0.
- Two-tile accumulate:
  - Stimulus: tile A is 8 vectors of 100 on all lanes (first=1, last=0), followed by tile B, 8 vectors of -30 (first=0, last=1).
  - Response: 8 results of 70 on all lanes, one per cycle, starting 8 cycles after tile B's first vector.
- Sign extension: lane 0 = -262144, tile_first=tile_last=1 -> out lane 0 = 0xFC0000 (-262144 in 24 bits); other lanes = 0.
- Overflow:
  - Stimulus: out_ready=0, 5 consecutive last vectors with values 1..5.
  - Response: out_valid=1, ovf=1 after the 5th push.
  - Draining yields 1,2,3,4 only. A full-FIFO push with a simultaneous pop does not set ovf.
- Wrap: 16 first=1,last=1 vectors with value v=i -> 16 results equal to i, in order; ptr returns to 0.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle during cycle 4 of a single pass.
  - Response: no output for that vector; out_valid=0, ovf=0, busy=0 immediately after reset.
  - A following single pass behaves as in scenario 1.

Source files
------------

// File: rtl/psum_deskew_acc.sv
// Output stage of the weight-stationary systolic array: realigns the skewed row
// partial sums, accumulates them across K-tiles and queues finished vectors.
module psum_deskew_acc #(
    parameter int ROWS       = 8,
    parameter int PSUM_BW    = 19,
    parameter int ACC_BW     = 24,
    parameter int VEC_CNT    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROWS*PSUM_BW-1:0]   psum_in,
    input  logic                      psum_valid,
    input  logic                      tile_first,
    input  logic                      tile_last,
    output logic [ROWS*ACC_BW-1:0]    out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      ovf,
    output logic                      busy
);

    localparam int STG   = ROWS - 1;
    localparam int PTR_W = (VEC_CNT > 1) ? $clog2(VEC_CNT) : 1;
    localparam int FP_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [STG-1:0] vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;
    logic [ROWS-1:0][PSUM_BW-1:0] lane_s;
    logic [ROWS-1:0][ACC_BW-1:0]  sum_s;
    logic [ROWS-1:0][ACC_BW-1:0]  acc_q [VEC_CNT];
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic [ROWS*ACC_BW-1:0] mem_q [FIFO_DEPTH];
    logic [FP_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, busy_q, ovf_q, ovf_d;
    logic             algn_vld_s, algn_fst_s, algn_lst_s;
    logic             push_s, pop_s, full_s, wr_en_s, drop_s;

    function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
        logic [FP_W-1:0] n;
        if (p == FP_W'(FIFO_DEPTH - 1)) begin
            n = {FP_W{1'b0}};
        end else begin
            n = p + FP_W'(1);
        end
        return n;
    endfunction

    // Lane r waits ROWS-1-r cycles so every lane lines up with the last row.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int D = ROWS - 1 - r;
        if (D == 0) begin : g_direct
            assign lane_s[r] = psum_in[r*PSUM_BW +: PSUM_BW];
        end else begin : g_dly
            logic [PSUM_BW-1:0] sr_q [D];
            // Per-lane skew shift register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) sr_q[i] <= '0;
                end else begin
                    sr_q[0] <= psum_in[r*PSUM_BW +: PSUM_BW];
                    for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign lane_s[r] = sr_q[D-1];
        end
    end

    assign algn_vld_s = vld_q[STG-1];
    assign algn_fst_s = fst_q[STG-1];
    assign algn_lst_s = lst_q[STG-1];

    // Control shift, accumulation sum and accumulator pointer next state
    always_comb begin
        vld_d = {vld_q[STG-2:0], psum_valid};
        fst_d = {fst_q[STG-2:0], tile_first};
        lst_d = {lst_q[STG-2:0], tile_last};
        for (int r = 0; r < ROWS; r++) begin
            sum_s[r] = (algn_fst_s ? {ACC_BW{1'b0}} : acc_q[ptr_q][r])
                     + {{(ACC_BW-PSUM_BW){lane_s[r][PSUM_BW-1]}}, lane_s[r]};
        end
        if (!algn_vld_s) begin
            ptr_d = ptr_q;
        end else if (ptr_q == PTR_W'(VEC_CNT - 1)) begin
            ptr_d = {PTR_W{1'b0}};
        end else begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // FIFO control; a full push is only dropped when no pop frees a slot
    always_comb begin
        push_s  = algn_vld_s && algn_lst_s;
        pop_s   = (cnt_q != {CNT_W{1'b0}}) && out_ready;
        full_s  = (cnt_q == CNT_W'(FIFO_DEPTH));
        wr_en_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;
        ovf_d   = ovf_q || drop_s;
        wr_d    = wr_en_s ? fifo_inc(wr_q) : wr_q;
        rd_d    = pop_s ? fifo_inc(rd_q) : rd_q;
        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Accumulator bank; tile_first defines contents so no reset is needed
    always_ff @(posedge clk) begin
        if (algn_vld_s) acc_q[ptr_q] <= sum_s;
    end

    // Pipeline control, pointer, FIFO and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            fst_q       <= '0;
            lst_q       <= '0;
            ptr_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            vld_q       <= vld_d;
            fst_q       <= fst_d;
            lst_q       <= lst_d;
            ptr_q       <= ptr_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (cnt_d != {CNT_W{1'b0}});
            busy_q      <= (|vld_d) || (cnt_d != {CNT_W{1'b0}});
            ovf_q       <= ovf_d;
            if (wr_en_s) mem_q[wr_q] <= sum_s;
        end
    end

    assign out_data  = mem_q[rd_q];
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule
